// File: rtl/dmux12_pkg.sv
// Shared definitions for the dmux12 1:2 TDM demultiplexer: FSM encoding, slot codes,
// default sample width.
package dmux12_pkg;

    localparam int unsigned DMUX12_WIDTH = 8;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] EXP_A = 2'b01;
    localparam logic [1:0] EXP_B = 2'b10;

    localparam logic SLOT_A = 1'b0;
    localparam logic SLOT_B = 1'b1;

endpackage

// File: rtl/dmux12_slot_ctrl.sv
// Slot-tracking FSM for dmux12_tdm: decides which channel register loads on each accepted
// sample, produces the expected-slot indicator and the sticky sync-error flag.
module dmux12_slot_ctrl
    import dmux12_pkg::*;
(
    input  logic CLK,
    input  logic RSTbar,
    input  logic accept,
    input  logic FSYNC,
    output logic load_a,
    output logic load_b,
    output logic pair,
    output logic SEL,
    output logic ERR
);

    logic [1:0] state_q, state_d;
    logic       err_q, err_d;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        load_a  = 1'b0;
        load_b  = 1'b0;
        pair    = 1'b0;
        case (state_q)
            IDLE: begin
                // Samples without frame sync are dropped silently until alignment is found.
                if (accept && FSYNC) begin
                    load_a  = 1'b1;
                    state_d = EXP_B;
                end
            end
            EXP_B: begin
                if (accept) begin
                    if (!FSYNC) begin
                        load_b  = 1'b1;
                        pair    = 1'b1;
                        state_d = EXP_A;
                    end else begin
                        // Premature frame start: restart the frame on this A sample.
                        load_a  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            EXP_A: begin
                if (accept) begin
                    if (FSYNC) begin
                        load_a  = 1'b1;
                        state_d = EXP_B;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign SEL = (state_q == EXP_B) ? SLOT_B : SLOT_A;
    assign ERR = err_q;

endmodule

// File: rtl/dmux12_tdm.sv
// Clocked 1:2 time-division demultiplexer: splits an A/B interleaved stream into two
// channel registers with strobes. Optional parity check enabled by DMUX12_PARITY_EN.
module dmux12_tdm
    import dmux12_pkg::*;
#(
    parameter int unsigned WIDTH = DMUX12_WIDTH
) (
    input  logic             CLK,
    input  logic             RSTbar,
    input  logic             Gbar,
    input  logic [WIDTH-1:0] D,
    input  logic             DV,
    input  logic             FSYNC,
`ifdef DMUX12_PARITY_EN
    input  logic             DP,
    output logic             PERR,
`endif
    output logic [WIDTH-1:0] YA,
    output logic [WIDTH-1:0] YB,
    output logic             VA,
    output logic             VB,
    output logic             PV,
    output logic             SEL,
    output logic             ERR
);

    logic             present;
    logic             accept;
    logic             load_a, load_b, pair;
    logic [WIDTH-1:0] ya_q, ya_d;
    logic [WIDTH-1:0] yb_q, yb_d;
    logic             va_q, va_d;
    logic             vb_q, vb_d;
    logic             pv_q, pv_d;

    assign present = !Gbar && DV;

`ifdef DMUX12_PARITY_EN
    logic par_ok;
    logic perr_q, perr_d;

    // Even parity: DP makes the total number of ones across D and DP even.
    assign par_ok = ((^D) == DP);
    assign accept = present && par_ok;
    assign perr_d = present && !par_ok;

    always_ff @(posedge CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign PERR = perr_q;
`else
    assign accept = present;
`endif

    dmux12_slot_ctrl u_slot_ctrl (
        .CLK    (CLK),
        .RSTbar (RSTbar),
        .accept (accept),
        .FSYNC  (FSYNC),
        .load_a (load_a),
        .load_b (load_b),
        .pair   (pair),
        .SEL    (SEL),
        .ERR    (ERR)
    );

    always_comb begin
        ya_d = ya_q;
        yb_d = yb_q;
        if (load_a) begin
            ya_d = D;
        end
        if (load_b) begin
            yb_d = D;
        end
        va_d = load_a;
        vb_d = load_b;
        pv_d = pair;
    end

    always_ff @(posedge CLK or negedge RSTbar) begin
        if (!RSTbar) begin
            ya_q <= '0;
            yb_q <= '0;
            va_q <= 1'b0;
            vb_q <= 1'b0;
            pv_q <= 1'b0;
        end else begin
            ya_q <= ya_d;
            yb_q <= yb_d;
            va_q <= va_d;
            vb_q <= vb_d;
            pv_q <= pv_d;
        end
    end

    assign YA = ya_q;
    assign YB = yb_q;
    assign VA = va_q;
    assign VB = vb_q;
    assign PV = pv_q;

endmodule

// File: tb/tb_dmux12_tdm.sv
// Scoreboard bench for dmux12_tdm: stimulus pushes expected strobe events, a negedge
// monitor pops and compares whenever a strobe appears.
module tb_dmux12_tdm;

    typedef struct packed {
        logic       va;
        logic       vb;
        logic       pv;
        logic       perr;
        logic [7:0] ya;
        logic [7:0] yb;
    } ev_t;

    logic       CLK = 1'b0;
    logic       RSTbar = 1'b0;
    logic       Gbar = 1'b0;
    logic [7:0] D = 8'h00;
    logic       DV = 1'b0;
    logic       FSYNC = 1'b0;
    logic       DP = 1'b0;
    logic [7:0] YA, YB;
    logic       VA, VB, PV, SEL, ERR;
    logic       perr_w;

    int   total = 0;
    int   bad = 0;
    ev_t  exp_q[$];

    always #5 CLK = ~CLK;

    dmux12_tdm #(.WIDTH(8)) dut (
        .CLK    (CLK),
        .RSTbar (RSTbar),
        .Gbar   (Gbar),
        .D      (D),
        .DV     (DV),
        .FSYNC  (FSYNC),
`ifdef DMUX12_PARITY_EN
        .DP     (DP),
        .PERR   (perr_w),
`endif
        .YA     (YA),
        .YB     (YB),
        .VA     (VA),
        .VB     (VB),
        .PV     (PV),
        .SEL    (SEL),
        .ERR    (ERR)
    );

`ifndef DMUX12_PARITY_EN
    assign perr_w = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic ev_t mk(input logic va, input logic vb, input logic pv, input logic perr,
                               input logic [7:0] ya, input logic [7:0] yb);
        ev_t e;
        e.va = va; e.vb = vb; e.pv = pv; e.perr = perr; e.ya = ya; e.yb = yb;
        return e;
    endfunction

    // Monitor: every strobe cycle must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (RSTbar && (VA || VB || PV || perr_w)) begin
            ev_t act;
            act = mk(VA, VB, PV, perr_w, YA, YB);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {12'h0, act}, 32'h0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("strobe_event", {12'h0, act}, {12'h0, e});
            end
        end
    end

    // Drive one sample for one cycle; DV stays high so calls can run back to back.
    task automatic send(input logic [7:0] d, input logic fs, input logic par_bad,
                        input logic push, input ev_t ev);
        D     = d;
        FSYNC = fs;
        DV    = 1'b1;
        DP    = (^d) ^ par_bad;
        if (push) exp_q.push_back(ev);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        DV    = 1'b0;
        FSYNC = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        DV     = 1'b0;
        FSYNC  = 1'b0;
        Gbar   = 1'b0;
        RSTbar = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_outputs", {YA, YB, VA, VB, PV, SEL, ERR}, 32'h0);
        RSTbar = 1'b1;
    endtask

    initial begin
        // Basic frame
        do_reset();
        chk("sel_before_a", SEL, 1'b0);
        send(8'h3C, 1'b1, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'h3C, 8'h00));
        chk("sel_after_a", SEL, 1'b1);
        send(8'hA5, 1'b0, 1'b0, 1'b1, mk(0, 1, 1, 0, 8'h3C, 8'hA5));
        chk("sel_after_b", SEL, 1'b0);
        chk("err_clean", ERR, 1'b0);
        idle(2);

        // Gated: nothing may be captured or strobed
        do_reset();
        Gbar  = 1'b1;
        DV    = 1'b1;
        FSYNC = 1'b1;
        D     = 8'hFF;
        DP    = 1'b0;
        repeat (4) begin
            @(posedge CLK);
            #1;
        end
        chk("gated_ya", YA, 8'h00);
        chk("gated_sel", SEL, 1'b0);
        Gbar = 1'b0;
        send(8'h10, 1'b1, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'h10, 8'h00));
        send(8'h20, 1'b0, 1'b0, 1'b1, mk(0, 1, 1, 0, 8'h10, 8'h20));
        idle(1);

        // Alignment loss in EXP_A
        send(8'h11, 1'b0, 1'b0, 1'b0, '0);
        chk("lost_err", ERR, 1'b1);
        chk("lost_sel", SEL, 1'b0);
        chk("lost_ya_kept", YA, 8'h10);
        send(8'h22, 1'b1, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'h22, 8'h20));
        send(8'h33, 1'b0, 1'b0, 1'b1, mk(0, 1, 1, 0, 8'h22, 8'h33));
        idle(1);

        // Premature frame in EXP_B
        do_reset();
        send(8'h44, 1'b1, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'h44, 8'h00));
        send(8'h55, 1'b1, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'h55, 8'h00));
        chk("prem_err", ERR, 1'b1);
        chk("prem_sel", SEL, 1'b1);
        send(8'h66, 1'b0, 1'b0, 1'b1, mk(0, 1, 1, 0, 8'h55, 8'h66));
        idle(1);

        // Full-rate frames, then asynchronous reset mid-frame
        do_reset();
        send(8'h01, 1'b1, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'h01, 8'h00));
        send(8'h02, 1'b0, 1'b0, 1'b1, mk(0, 1, 1, 0, 8'h01, 8'h02));
        send(8'h03, 1'b1, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'h03, 8'h02));
        send(8'h04, 1'b0, 1'b0, 1'b1, mk(0, 1, 1, 0, 8'h03, 8'h04));
        send(8'h05, 1'b1, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'h05, 8'h04));
        send(8'h06, 1'b0, 1'b0, 1'b1, mk(0, 1, 1, 0, 8'h05, 8'h06));
        chk("burst_final", {YA, YB}, 16'h0506);
        send(8'h07, 1'b1, 1'b0, 1'b0, '0);
        chk("midframe_va", {VA, YA, SEL}, {1'b1, 8'h07, 1'b1});
        #1;
        RSTbar = 1'b0;
        #1;
        chk("async_rst", {YA, YB, VA, VB, PV, SEL, ERR}, 32'h0);
        DV = 1'b0;
        @(posedge CLK);
        #1;
        RSTbar = 1'b1;
        idle(1);

`ifdef DMUX12_PARITY_EN
        // Parity mismatch drops the sample; matching parity captures normally
        send(8'h07, 1'b1, 1'b1, 1'b1, mk(0, 0, 0, 1, 8'h00, 8'h00));
        chk("perr_sel", SEL, 1'b0);
        chk("perr_err", ERR, 1'b0);
        send(8'h07, 1'b1, 1'b0, 1'b1, mk(1, 0, 0, 0, 8'h07, 8'h00));
        chk("par_ok_sel", SEL, 1'b1);
        idle(1);
`endif

        idle(2);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
